// File: rtl/secuenciador_cuenta_pkg.sv
// Shared types and defaults for the cuenta1 launcher: FSM state encoding,
// default operand/result widths and the result code reported on a timeout.
package secuenciador_pkg;

   localparam int VALOR_W_DEF  = 3;
   localparam int CUENTA_W_DEF = 4;

   // Wide enough for any result width; the top slices it down to CUENTA_W.
   localparam logic [31:0] CUENTA_ERR = '1;

   typedef enum logic [1:0] {
      IDLE,
      LANZA,
      ESPERA,
      ENTREGA
   } estado_t;

endpackage

// File: rtl/secuenciador_cuenta_if.sv
// Operand, counter and result handshakes of the cuenta1 launcher.
// The slave modport is the launcher's view; master is the surroundings' view.
interface secuenciador_cuenta_if #(
   parameter int VALOR_W  = 3,
   parameter int CUENTA_W = 4
);
   logic [VALOR_W-1:0]  in_valor;
   logic                in_valid;
   logic                in_ready;
   logic [VALOR_W-1:0]  valor;
   logic                start;
   logic [CUENTA_W-1:0] cuenta;
   logic                fin;
   logic [CUENTA_W-1:0] res_cuenta;
   logic                res_valid;
   logic                res_ready;
   logic                res_err;

   modport slave (
      input  in_valor, in_valid, cuenta, fin, res_ready,
      output in_ready, valor, start, res_cuenta, res_valid, res_err
   );

   modport master (
      output in_valor, in_valid, cuenta, fin, res_ready,
      input  in_ready, valor, start, res_cuenta, res_valid, res_err
   );

endinterface

// File: rtl/secuenciador_cuenta_fifo.sv
// fifo_valores: operand queue of DEPTH entries (power of two) with fill count.
// Pushes when full and pops when empty are dropped inside the queue.
module fifo_valores #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LLENO = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == LLENO);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap on their own because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/secuenciador_cuenta.sv
// secuenciador_cuenta: queues operands, launches cuenta1 one job at a time and
// returns each Cuenta downstream. Optional fin timeout: SECUENCIADOR_TIMEOUT_EN.
module secuenciador_cuenta
   import secuenciador_pkg::*;
#(
   parameter int VALOR_W     = VALOR_W_DEF,
   parameter int CUENTA_W    = CUENTA_W_DEF,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   secuenciador_cuenta_if.slave   bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] ocupacion
);
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
      $error("secuenciador_cuenta: DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
   end

   estado_t             estado, estado_sig;
   logic                pop, capturar, entregar, expira;
   logic                fifo_full, fifo_empty;
   logic [VALOR_W-1:0]  cabeza;
   logic [VALOR_W-1:0]  valor_q;
   logic [CUENTA_W-1:0] res_cuenta_q;
   logic                res_valid_q;
   logic                fin_q;

   fifo_valores #(.DEPTH(DEPTH), .W(VALOR_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (bus.in_valid),
      .pop     (pop),
      .wr_data (bus.in_valor),
      .rd_data (cabeza),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (ocupacion)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= IDLE;
      else        estado <= estado_sig;
   end

   // Only a fresh fin rise counts, so a level left over from the last job is ignored.
   always_comb begin
      estado_sig = estado;
      pop        = 1'b0;
      capturar   = 1'b0;
      entregar   = 1'b0;
      case (estado)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               estado_sig = LANZA;
            end
         end
         LANZA:   estado_sig = ESPERA;
         ESPERA: begin
            if (bus.fin && !fin_q) begin
               capturar   = 1'b1;
               estado_sig = ENTREGA;
            end else if (expira) begin
               estado_sig = ENTREGA;
            end
         end
         ENTREGA: begin
            if (res_valid_q && bus.res_ready) begin
               entregar   = 1'b1;
               estado_sig = IDLE;
            end
         end
         default: estado_sig = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valor_q      <= '0;
         res_cuenta_q <= '0;
         res_valid_q  <= 1'b0;
         fin_q        <= 1'b0;
      end else begin
         fin_q <= bus.fin;
         if (pop) valor_q <= cabeza;
         if (capturar) begin
            res_cuenta_q <= bus.cuenta;
            res_valid_q  <= 1'b1;
         end else if (expira) begin
            res_cuenta_q <= CUENTA_ERR[CUENTA_W-1:0];
            res_valid_q  <= 1'b1;
         end else if (entregar) begin
            res_valid_q  <= 1'b0;
         end
      end
   end

`ifdef SECUENCIADOR_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TMO_W-1:0] espera_cnt;
   logic             res_err_q;

   // Counts cycles spent in ESPERA; restarts from zero for every job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         espera_cnt <= '0;
         res_err_q  <= 1'b0;
      end else begin
         espera_cnt <= (estado == ESPERA) ? espera_cnt + 1'b1 : '0;
         if (expira)        res_err_q <= 1'b1;
         else if (entregar) res_err_q <= 1'b0;
      end
   end

   assign expira      = (estado == ESPERA) && (espera_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign bus.res_err = res_err_q;
`else
   assign expira      = 1'b0;
   assign bus.res_err = 1'b0;
`endif

   assign bus.in_ready   = ~fifo_full;
   assign bus.valor      = valor_q;
   assign bus.start      = (estado == LANZA);
   assign bus.res_cuenta = res_cuenta_q;
   assign bus.res_valid  = res_valid_q;
   assign busy           = (estado != IDLE);

endmodule

// File: tb/tb_secuenciador_cuenta.sv
// Directed bench for secuenciador_cuenta with a small cuenta1 model that
// raises fin a fixed time after each start and reports the operand as Cuenta.
module tb_secuenciador_cuenta;

   localparam int VALOR_W     = 3;
   localparam int CUENTA_W    = 4;
   localparam int DEPTH       = 4;
   localparam int TIMEOUT_CYC = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [2:0] ocupacion;

   int checks = 0;
   int errors = 0;

   secuenciador_cuenta_if #(.VALOR_W(VALOR_W), .CUENTA_W(CUENTA_W)) bus ();

   secuenciador_cuenta #(
      .VALOR_W     (VALOR_W),
      .CUENTA_W    (CUENTA_W),
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .ocupacion (ocupacion)
   );

   always #5 clk = ~clk;

   // Counter model: fin drops one cycle into the job and rises 6 cycles after start.
   logic       model_auto = 1'b1;
   logic       model_fin = 1'b0;
   logic       man_fin = 1'b0;
   logic [3:0] model_cuenta = 4'h0;
   logic [3:0] man_cuenta = 4'h0;
   logic [2:0] model_val = 3'h0;
   logic       valor_moved = 1'b0;
   int         model_cnt = 0;

   assign bus.fin    = model_auto ? model_fin : man_fin;
   assign bus.cuenta = model_auto ? model_cuenta : man_cuenta;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_cnt <= 0;
         model_fin <= 1'b0;
      end else if (bus.start === 1'b1) begin
         model_cnt <= 1;
         model_val <= bus.valor;
      end else if (model_cnt != 0) begin
         if (bus.valor !== model_val) valor_moved <= 1'b1;
         if (model_cnt == 1) model_fin <= 1'b0;
         if (model_cnt == 5) begin
            model_fin    <= 1'b1;
            model_cuenta <= {1'b0, model_val};
            model_cnt    <= 0;
         end else begin
            model_cnt <= model_cnt + 1;
         end
      end
   end

   int         cycle = 0;
   int         start_count = 0;
   int         sc [32];
   logic [2:0] sv [32];

   always @(posedge clk) begin
      cycle = cycle + 1;
      if (bus.start === 1'b1) begin
         if (start_count < 32) begin
            sc[start_count] = cycle;
            sv[start_count] = bus.valor;
         end
         start_count = start_count + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] v);
      bus.in_valor = v;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag, input int budget);
      int n = 0;
      while (bus.res_valid !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
      checkOutput(tag, {31'b0, bus.res_valid}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=stuck expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] res_arr [3];
      int         got;
      int         sc_before;
      logic       held;

      bus.in_valor  = '0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;

      // Reset values
      step(2);
      checkOutput("rst_start",      bus.start,      0);
      checkOutput("rst_busy",       busy,           0);
      checkOutput("rst_ocupacion",  ocupacion,      0);
      checkOutput("rst_res_valid",  bus.res_valid,  0);
      checkOutput("rst_res_err",    bus.res_err,    0);
      checkOutput("rst_in_ready",   bus.in_ready,   1);
      checkOutput("rst_valor",      bus.valor,      0);
      checkOutput("rst_res_cuenta", bus.res_cuenta, 0);
      rst_n = 1'b1;
      step(1);

      // Single job with operand 5, result held until accepted
      applyStimulus(3'b101);
      checkOutput("one_ocup_push", ocupacion, 1);
      checkOutput("one_busy_push", busy, 0);
      step(1);
      checkOutput("one_start",     bus.start, 1);
      checkOutput("one_valor",     bus.valor, 5);
      checkOutput("one_ocup_pop",  ocupacion, 0);
      step(1);
      checkOutput("one_start_end", bus.start, 0);
      checkOutput("one_busy",      busy, 1);
      waitResult("one_result", 20);
      checkOutput("one_res_cuenta", bus.res_cuenta, 5);
      checkOutput("one_res_err",    bus.res_err, 0);
      step(3);
      checkOutput("one_hold_valid",  bus.res_valid, 1);
      checkOutput("one_hold_cuenta", bus.res_cuenta, 5);
      checkOutput("one_start_count", start_count, 1);
      bus.res_ready = 1'b1;
      step(1);
      checkOutput("one_accepted", bus.res_valid, 0);
      checkOutput("one_idle",     busy, 0);

      // Three back-to-back operands; push and pop meet on the second edge
      applyStimulus(3'd5);
      applyStimulus(3'd3);
      applyStimulus(3'd7);
      checkOutput("seq_ocup", ocupacion, 2);
      got = 0;
      res_arr[0] = 4'hx; res_arr[1] = 4'hx; res_arr[2] = 4'hx;
      for (int i = 0; i < 60 && got < 3; i++) begin
         step(1);
         if (bus.res_valid === 1'b1) begin
            res_arr[got] = bus.res_cuenta;
            got++;
         end
      end
      checkOutput("seq_count", got, 3);
      checkOutput("seq_res0", res_arr[0], 5);
      checkOutput("seq_res1", res_arr[1], 3);
      checkOutput("seq_res2", res_arr[2], 7);
      checkOutput("seq_starts", start_count, 4);
      checkOutput("seq_valor0", sv[1], 5);
      checkOutput("seq_valor1", sv[2], 3);
      checkOutput("seq_valor2", sv[3], 7);
      checkOutput("seq_gap01", sc[2] - sc[1], 9);
      checkOutput("seq_gap12", sc[3] - sc[2], 9);
      step(2);
      checkOutput("seq_idle", busy, 0);

      // Stalled counter: fill the queue, fifth push dropped
      model_auto = 1'b0;
      man_fin    = 1'b0;
      step(1);
      applyStimulus(3'd2);
      step(2);
      applyStimulus(3'd1);
      applyStimulus(3'd6);
      applyStimulus(3'd3);
      applyStimulus(3'd4);
      checkOutput("full_ocup",     ocupacion, 4);
      checkOutput("full_in_ready", bus.in_ready, 0);
      applyStimulus(3'd0);
      checkOutput("full_drop_ocup", ocupacion, 4);
      checkOutput("full_busy",      busy, 1);
      checkOutput("full_no_result", bus.res_valid, 0);
      man_cuenta = 4'h9;
      man_fin    = 1'b1;
      step(1);
      checkOutput("full_res_valid",  bus.res_valid, 1);
      checkOutput("full_res_cuenta", bus.res_cuenta, 9);
      step(2);
      checkOutput("full_next_valor", bus.valor, 1);
      checkOutput("full_ocup_after", ocupacion, 3);

      // fin still high from the previous job must not be captured
      bus.res_ready = 1'b0;
      step(1);
      step(5);
      checkOutput("stale_fin_no_capture", bus.res_valid, 0);
      checkOutput("stale_fin_busy", busy, 1);
      man_fin = 1'b0;
      step(1);
      man_fin    = 1'b1;
      man_cuenta = 4'hA;
      step(1);
      checkOutput("stale_res_valid",  bus.res_valid, 1);
      checkOutput("stale_res_cuenta", bus.res_cuenta, 4'hA);
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (bus.res_valid !== 1'b1 || bus.res_cuenta !== 4'hA) held = 1'b0;
      end
      checkOutput("stale_held_10", held, 1);
      bus.res_ready = 1'b1;
      step(1);
      checkOutput("stale_accepted", bus.res_valid, 0);

      // Reset mid-ESPERA with two operands still queued
      step(2);
      checkOutput("midrst_pre_ocup", ocupacion, 2);
      checkOutput("midrst_pre_busy", busy, 1);
      sc_before = start_count;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_start",     bus.start, 0);
      checkOutput("midrst_ocup",      ocupacion, 0);
      checkOutput("midrst_res_valid", bus.res_valid, 0);
      checkOutput("midrst_busy",      busy, 0);
      checkOutput("midrst_in_ready",  bus.in_ready, 1);
      step(1);
      rst_n = 1'b1;
      step(20);
      checkOutput("midrst_no_start", start_count, sc_before);
      checkOutput("midrst_idle",     busy, 0);

      // fin never rises
      man_fin       = 1'b0;
      bus.res_ready = 1'b0;
      applyStimulus(3'd4);
      step(64);
      checkOutput("tmo_not_yet", bus.res_valid, 0);
      step(2);
`ifdef SECUENCIADOR_TIMEOUT_EN
      checkOutput("tmo_res_valid",  bus.res_valid, 1);
      checkOutput("tmo_res_err",    bus.res_err, 1);
      checkOutput("tmo_res_cuenta", bus.res_cuenta, 4'hF);
      step(3);
      checkOutput("tmo_hold_err", bus.res_err, 1);
      bus.res_ready = 1'b1;
      step(1);
      checkOutput("tmo_clear_valid", bus.res_valid, 0);
      checkOutput("tmo_clear_err",   bus.res_err, 0);
`else
      checkOutput("wait_res_valid", bus.res_valid, 0);
      checkOutput("wait_res_err",   bus.res_err, 0);
      checkOutput("wait_busy",      busy, 1);
`endif

      checkOutput("valor_stable", valor_moved, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
